// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch controller: FSM states, button bit
// positions and the default saturation limit.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    S_STOP = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2
  } sw_state_e;

  localparam int BTN_DOWN  = 0;
  localparam int BTN_UP    = 1;
  localparam int BTN_STOP  = 2;
  localparam int BTN_CLEAR = 3;
  localparam int BTN_LAP   = 4;

  localparam int CNT_MAX_DEF = 9999;
  localparam int CNT_W       = 14;

endpackage

// File: rtl/rate_prescaler.sv
// Tick generator: one-cycle tick every 2^rate clocks, restartable by clr.
module rate_prescaler #(
  parameter int RATE_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [RATE_W-1:0] rate,
  output logic              tick
);

  logic [31:0] cnt_q, cnt_d, limit;

  // >= rather than == so a shrinking period mid-count can never lock up.
  always_comb begin
    limit = (32'd1 << rate) - 32'd1;
    tick  = (cnt_q >= limit);
    cnt_d = (tick || clr) ? 32'd0 : cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= 32'd0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: up/down/stop FSM, saturating counter on prescaled
// ticks, and a lap register that freezes the displayed value.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CNT_MAX = CNT_MAX_DEF,
  parameter int RATE_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        btn,
  input  logic [RATE_W-1:0] rate,
  output logic [13:0]       count,
  output logic [13:0]       disp_value,
  output logic [2:0]        led,
  output logic              lap_active
);

  localparam logic [13:0] MAX_V = 14'(CNT_MAX);

  sw_state_e   state_q, state_d;
  logic [4:0]  btn_q, press;
  logic [13:0] count_q, count_d, lap_q, lap_d;
  logic        lap_active_q, lap_active_d;
  logic        tick, clr;

  assign press = btn & ~btn_q;
  assign clr   = press[BTN_CLEAR];

  rate_prescaler #(.RATE_W(RATE_W)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .rate  (rate),
    .tick  (tick)
  );

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    lap_d        = lap_q;
    lap_active_d = lap_active_q;

    if (clr)                     state_d = S_STOP;
    else if (press[BTN_STOP])    state_d = S_STOP;
    else if (press[BTN_UP])      state_d = S_UP;
    else if (press[BTN_DOWN])    state_d = S_DOWN;

    // Ticks act on the registered state; a same-cycle press only moves the FSM.
    if (clr) begin
      count_d = '0;
    end else if (tick) begin
      if (state_q == S_UP && count_q < MAX_V)     count_d = count_q + 14'd1;
      else if (state_q == S_DOWN && count_q != '0) count_d = count_q - 14'd1;
    end

    if (clr) begin
      lap_d        = '0;
      lap_active_d = 1'b0;
    end else if (press[BTN_LAP]) begin
      if (lap_active_q) begin
        lap_active_d = 1'b0;
      end else if (state_q != S_STOP) begin
        lap_d        = count_q;
        lap_active_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_STOP;
      count_q      <= '0;
      lap_q        <= '0;
      lap_active_q <= 1'b0;
      btn_q        <= 5'b11111;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      lap_q        <= lap_d;
      lap_active_q <= lap_active_d;
      btn_q        <= btn;
    end
  end

  assign count      = count_q;
  assign lap_active = lap_active_q;
  assign disp_value = lap_active_q ? lap_q : count_q;
  assign led[2]     = (count_q == MAX_V && state_q == S_UP) ||
                      (count_q == '0 && state_q == S_DOWN);
  assign led[1]     = (state_q == S_UP);
  assign led[0]     = (state_q == S_DOWN);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: counting, saturation, priority, lap,
// prescaler rate change and reset behaviour.
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  btn;
  logic [4:0]  rate;
  logic [13:0] count, disp_value;
  logic [2:0]  led;
  logic        lap_active;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [4:0] B_DOWN = 5'b00001, B_UP = 5'b00010, B_STOP = 5'b00100,
                         B_CLR  = 5'b01000, B_LAP = 5'b10000;

  stopwatch_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn        (btn),
    .rate       (rate),
    .count      (count),
    .disp_value (disp_value),
    .led        (led),
    .lap_active (lap_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [4:0] b);
    btn = b;
    step();
    btn = 5'b0;
  endtask

  initial begin
    rst_n = 1'b0; btn = 5'b0; rate = 5'd0;
    step(3);
    rst_n = 1'b1;
    chk("rst_count", 32'(count), 0);
    chk("rst_disp", 32'(disp_value), 0);
    chk("rst_led", 32'(led), 0);
    chk("rst_lap", 32'(lap_active), 0);
    step(2);
    chk("stop_hold", 32'(count), 0);

    // Up at rate 0: one increment per cycle
    press(B_UP);
    chk("up_start", 32'(count), 0);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk($sformatf("up_%0d", i), 32'(count), 32'(i));
    end
    chk("up_led", 32'(led), 32'b010);

    // Run to 9998, then rate 2: next tick after 4 cycles, then saturate
    step(9993);
    chk("pre_sat", 32'(count), 9998);
    rate = 5'd2;
    step(3);
    chk("sat_wait", 32'(count), 9998);
    step(5);
    chk("sat_count", 32'(count), 9999);
    chk("sat_led", 32'(led), 32'b110);

    // Clear, count up to 2, then switch to down (that edge's tick still counts up)
    rate = 5'd0;
    press(B_CLR);
    chk("clr_count", 32'(count), 0);
    chk("clr_led", 32'(led), 0);
    press(B_UP);
    step(2);
    chk("up_to2", 32'(count), 2);
    press(B_DOWN);
    chk("down_entry", 32'(count), 3);
    chk("down_led", 32'(led), 32'b001);
    press(B_STOP);
    chk("stop_tick", 32'(count), 2);
    step(3);
    chk("stop_hold2", 32'(count), 2);
    chk("stop_led", 32'(led), 0);

    // Down saturates at 0
    press(B_DOWN);
    chk("down_start", 32'(count), 2);
    step(3);
    chk("down_sat", 32'(count), 0);
    chk("down_sat_led", 32'(led), 32'b101);

    // Rate decrease mid-period ticks on the next cycle
    press(B_UP);
    rate = 5'd4;
    step(5);
    chk("slow_hold", 32'(count), 0);
    rate = 5'd1;
    step();
    chk("rate_drop", 32'(count), 1);
    step(2);
    chk("rate1_tick", 32'(count), 2);

    // Lap capture keeps display frozen while counting continues
    rate = 5'd0;
    step(38);
    chk("to40", 32'(count), 40);
    press(B_LAP);
    chk("lap_disp", 32'(disp_value), 40);
    chk("lap_act", 32'(lap_active), 1);
    step(4);
    chk("lap_count", 32'(count), 45);
    chk("lap_disp2", 32'(disp_value), 40);
    press(B_LAP);
    chk("unlap_act", 32'(lap_active), 0);
    chk("unlap_disp", 32'(disp_value), 46);

    // Clear beats up; also drops a held lap
    step(30);
    press(B_LAP);
    chk("to77", 32'(count), 77);
    chk("lap76", 32'(disp_value), 76);
    press(B_CLR | B_UP);
    chk("cu_count", 32'(count), 0);
    chk("cu_lap", 32'(lap_active), 0);
    chk("cu_led", 32'(led), 0);
    step(2);
    chk("cu_hold", 32'(count), 0);
    press(B_LAP);
    chk("lap_in_stop", 32'(lap_active), 0);

    // Button held through reset release must not fire
    btn = B_UP;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(4);
    chk("held_led", 32'(led), 0);
    chk("held_count", 32'(count), 0);
    btn = 5'b0;
    step();
    press(B_UP);
    chk("repress_led", 32'(led), 32'b010);
    step(3);
    chk("repress_cnt", 32'(count), 3);

    // Reset mid-count leaves nothing behind
    rst_n = 1'b0;
    step();
    chk("midrst_count", 32'(count), 0);
    rst_n = 1'b1;
    step(2);
    chk("midrst_hold", 32'(count), 0);
    chk("midrst_led", 32'(led), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter CNT_MAX, default 9999: saturation limit of the count; SHALL fit in 14 bits.
REQ-002 Parameter RATE_W, default 5: width of the rate-exponent input.
REQ-003 clk  input  1  single system clock; all state SHALL be updated on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 btn  input  5  synchronized, level-sensitive push buttons: [4] lap, [3] clear, [2] stop, [1] up, [0] down.
REQ-006 rate  input  RATE_W  tick period exponent; tick period SHALL be 2^rate clk cycles.
REQ-007 count  output  14  live count value.
REQ-008 disp_value  output  14  value for the display driver: the lap register while a lap is held, otherwise count.
REQ-009 led  output  3  [2] saturated, [1] counting up, [0] counting down.
REQ-010 lap_active  output  1  high while a lap value is held.

Function
REQ-011 Each button SHALL act only on its press edge: (btn & ~btn_q) = 1, with btn_q registered from btn each cycle; a held level SHALL NOT retrigger.
REQ-012 Press priority, highest first: clear > stop > up > down; lap SHALL be evaluated independently of the other four.
REQ-013 FSM states: STOP, UP, DOWN.
REQ-014 Transitions: clear -> STOP from any state; stop -> STOP; up -> UP; down -> DOWN; no press -> state held.
REQ-015 A state change SHALL take effect on the clock edge after the press edge is seen.
REQ-016 Prescaler: a 32-bit counter SHALL raise tick for one cycle when it is >= (2^rate)-1, then return to 0; otherwise it SHALL increment.
REQ-017 Because the compare is >=, a decrease of rate mid-period SHALL cause a tick on the next cycle with no lock-up.
REQ-018 On tick in UP: count SHALL increment, saturating at CNT_MAX.
REQ-019 On tick in DOWN: count SHALL decrement, saturating at 0.
REQ-020 In STOP, count SHALL hold; the prescaler SHALL keep running.
REQ-021 A tick SHALL use the registered state of that cycle; a press in the same cycle SHALL NOT affect that tick.
REQ-022 Clear press SHALL set count=0, prescaler=0, lap_active=0, lap register=0, state=STOP; a tick in the same cycle SHALL be ignored.
REQ-023 Lap press with lap_active=0 in UP or DOWN SHALL capture count into the lap register and set lap_active=1.
REQ-024 Lap press with lap_active=1, in any state, SHALL clear lap_active.
REQ-025 Lap press with lap_active=0 in STOP SHALL have no effect.
REQ-026 Counting SHALL continue while a lap is held.
REQ-027 Lap press coinciding with a tick SHALL capture the pre-tick count.
REQ-028 led[2] SHALL be (count==CNT_MAX and state==UP) or (count==0 and state==DOWN).
REQ-029 led[1:0] SHALL be decoded combinationally from the state.
REQ-030 Latency from the tick cycle to the updated count SHALL be one cycle.

Reset
REQ-031 With rst_n=0 at a rising edge: state=STOP, count=0, lap register=0, lap_active=0, prescaler=0, btn_q=5'b11111 (so buttons held through reset do not fire).
REQ-032 After reset: disp_value=0 and led=3'b000.
REQ-033 Reset mid-count SHALL abort the operation with no residual tick.

Structure
REQ-034 Package stopwatch_pkg SHALL hold: the state encoding (STOP/UP/DOWN), the button index constants, and the CNT_MAX default.
REQ-035 One sub-module, rate_prescaler, SHALL hold the tick generator (inputs clk, rst_n, clr, rate; output tick).
REQ-036 The FSM, count, and lap logic SHALL stay in stopwatch_ctrl.

Verification
REQ-037 rate=0; up press; run 5 cycles -> count increments every cycle: 1,2,3,4,5; led=3'b010.
REQ-038 rate=2; count=9998; UP; run 8 cycles -> count reaches 9999 and holds; led=3'b110.
REQ-039 DOWN from count=3 with rate=0; stop pressed in the same cycle as a tick -> that tick decrements to 2; count then holds at 2; led=3'b000.
REQ-040 UP, count=40; lap press -> disp_value=40 and lap_active=1 while count continues to 45; second lap press -> disp_value=count.
REQ-041 Clear and up pressed together at count=77 -> count=0, state=STOP, lap_active=0.
REQ-042 btn held high through rst_n release -> no state change until the button is released and pressed again.
